// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin arbiter and chip-select sequencer sharing one
// SPI byte engine between a host command path and a housekeeping poller.
module spi_txn_scheduler #(
  parameter int unsigned LEN_W           = 4,
  parameter int unsigned CS_SETUP_CYCLES = 2,
  parameter int unsigned CS_HOLD_CYCLES  = 2,
  parameter int unsigned CS_IDLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       tx0,
  input  logic [7:0]       tx1,
  output logic             grant0,
  output logic             grant1,
  output logic             tx_ready0,
  output logic             tx_ready1,
  output logic             rx_valid0,
  output logic             rx_valid1,
  output logic [7:0]       rx_data,
  output logic             done0,
  output logic             done1,
  output logic             eng_start,
  output logic [7:0]       eng_tx,
  input  logic             eng_done,
  input  logic [7:0]       eng_rx,
  output logic             cs_n,
  output logic             busy,
  output logic             err
);

  localparam int unsigned SH_MAX  = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int unsigned CNT_MAX = (SH_MAX > CS_IDLE_CYCLES) ? SH_MAX : CS_IDLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, cnt_tgt;
  logic [WD_W-1:0]  wd, wd_d, wd_inc;
  logic             owner, owner_d, last_served, last_d, pick;
  logic [LEN_W-1:0] remaining, rem_d;
  logic [1:0]       grant_q, grant_d, tx_ready_q, tx_ready_d;
  logic [1:0]       rx_valid_q, rx_valid_d, done_q, done_d;
  logic             eng_start_d, cs_n_d, busy_d, err_d, cnt_hit, wd_hit;
  logic [7:0]       eng_tx_d, rx_data_d;

  assign grant0    = grant_q[0];
  assign grant1    = grant_q[1];
  assign tx_ready0 = tx_ready_q[0];
  assign tx_ready1 = tx_ready_q[1];
  assign rx_valid0 = rx_valid_q[0];
  assign rx_valid1 = rx_valid_q[1];
  assign done0     = done_q[0];
  assign done1     = done_q[1];

  // Saturating phase/watchdog counters and their terminal counts
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign wd_inc  = (wd == {WD_W{1'b1}}) ? wd : wd + WD_W'(1);
  assign cnt_tgt = (state == S_SETUP) ? CNT_W'(CS_SETUP_CYCLES - 1) :
                   (state == S_HOLD)  ? CNT_W'(CS_HOLD_CYCLES - 1)  :
                                        CNT_W'(CS_IDLE_CYCLES - 1);
  assign cnt_hit = (cnt == cnt_tgt);
  assign wd_hit  = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  // Tie goes to whoever was not served last; otherwise the sole requester
  assign pick    = (req0 && req1) ? ~last_served : req1;

  // State and registered-output update
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wd          <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      remaining   <= '0;
      grant_q     <= '0;
      tx_ready_q  <= '0;
      rx_valid_q  <= '0;
      done_q      <= '0;
      eng_start   <= 1'b0;
      eng_tx      <= '0;
      rx_data     <= '0;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_d;
      wd          <= wd_d;
      owner       <= owner_d;
      last_served <= last_d;
      remaining   <= rem_d;
      grant_q     <= grant_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      eng_start   <= eng_start_d;
      eng_tx      <= eng_tx_d;
      rx_data     <= rx_data_d;
      cs_n        <= cs_n_d;
      busy        <= busy_d;
      err         <= err_d;
    end
  end

  // Next-state: eng_done beats a coincident watchdog terminal count
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req0 || req1) state_nxt = S_SETUP;
      S_SETUP: if (cnt_hit) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_done)    state_nxt = (remaining == '0) ? S_HOLD : S_START;
        else if (wd_hit) state_nxt = S_HOLD;
      end
      S_HOLD:  if (cnt_hit) state_nxt = S_GAP;
      S_GAP:   if (cnt_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of datapath registers and pulses
  always_comb begin
    grant_d     = grant_q;
    cs_n_d      = cs_n;
    err_d       = err;
    eng_tx_d    = eng_tx;
    rx_data_d   = rx_data;
    owner_d     = owner;
    last_d      = last_served;
    rem_d       = remaining;
    tx_ready_d  = '0;
    rx_valid_d  = '0;
    done_d      = '0;
    eng_start_d = 1'b0;
    busy_d      = (state_nxt != S_IDLE);
    cnt_d       = (state_nxt != state) ? '0 : cnt_inc;
    wd_d        = (state == S_WAIT) ? wd_inc : '0;

    if (eng_done && (state != S_WAIT)) err_d = 1'b1;

    if (state_nxt == S_START) begin
      eng_start_d       = 1'b1;
      eng_tx_d          = owner ? tx1 : tx0;
      tx_ready_d[owner] = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = pick;
          rem_d   = pick ? len1 : len0;
          grant_d = pick ? 2'b10 : 2'b01;
          cs_n_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          rx_data_d         = eng_rx;
          rx_valid_d[owner] = 1'b1;
          if (remaining != '0) rem_d = remaining - LEN_W'(1);
        end else if (wd_hit) begin
          err_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_hit) begin
          done_d[owner] = 1'b1;
          grant_d       = '0;
          cs_n_d        = 1'b1;
          last_d        = owner;
        end
      end
      default: ;
    endcase
  end

endmodule
